// File: rtl/freq_counter_pkg.sv
// Shared types and constants for the frequency-counter display path.
package freq_counter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT,
        ST_DWELL
    } sched_state_e;

    localparam int DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'd9;
    localparam int DEFAULT_DWELL = 1200;

    function automatic logic [DIGIT_W-1:0] clamp_digit(input logic [DIGIT_W-1:0] d);
        return (d > DIGIT_MAX) ? DIGIT_MAX : d;
    endfunction

endpackage

// File: rtl/display_scheduler_if.sv
// Bundle between the measurement channels (master) and the display scheduler (slave),
// including the load port toward the seven-segment driver.
interface display_scheduler_if
    import freq_counter_pkg::*;
#(
    parameter int CHANNELS = 4
);
    localparam int CW = $clog2(CHANNELS);

    logic [CHANNELS-1:0]         req_valid;
    logic [DIGIT_W*CHANNELS-1:0] req_tens;
    logic [DIGIT_W*CHANNELS-1:0] req_units;
    logic [CHANNELS-1:0]         req_ready;
    logic                        disp_load;
    logic [DIGIT_W-1:0]          disp_tens;
    logic [DIGIT_W-1:0]          disp_units;
    logic [CW-1:0]               cur_chan;
    logic                        busy;

    modport master (
        output req_valid, req_tens, req_units,
        input  req_ready, disp_load, disp_tens, disp_units, cur_chan, busy
    );

    modport slave (
        input  req_valid, req_tens, req_units,
        output req_ready, disp_load, disp_tens, disp_units, cur_chan, busy
    );

endinterface

// File: rtl/display_scheduler_rr_pick.sv
// Combinational grant picker: round-robin after last_grant by default,
// lowest-index-wins when SCHED_PRIORITY_EN is defined.
module rr_pick #(
    parameter int CHANNELS = 4,
    parameter int CW = $clog2(CHANNELS)
) (
    input  logic [CHANNELS-1:0] full,
    input  logic [CW-1:0]       last_grant,
    output logic                any,
    output logic [CW-1:0]       grant
);

    logic found;

`ifdef SCHED_PRIORITY_EN
    logic unused_last_grant;
    assign unused_last_grant = ^last_grant;

    always_comb begin
        any   = |full;
        grant = '0;
        found = 1'b0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (!found && full[k]) begin
                grant = CW'(k);
                found = 1'b1;
            end
        end
    end
`else
    logic [CW-1:0] idx;

    // Search starts just after the previous winner so it is considered last.
    always_comb begin
        any   = |full;
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= CHANNELS; k++) begin
            idx = CW'((int'(last_grant) + k) % CHANNELS);
            if (!found && full[idx]) begin
                grant = idx;
                found = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/display_scheduler.sv
// Time-shares one two-digit display among CHANNELS measurement channels.
// Build option: define SCHED_PRIORITY_EN for fixed-priority instead of round-robin.
module display_scheduler
    import freq_counter_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int DWELL    = DEFAULT_DWELL
) (
    input logic               clk,
    input logic               reset,
    display_scheduler_if.slave bus
);

    localparam int CW    = $clog2(CHANNELS);
    localparam int CNT_W = $clog2(DWELL + 1);

    logic [CHANNELS-1:0]              slot_full_q,  slot_full_d;
    logic [CHANNELS-1:0][DIGIT_W-1:0] slot_tens_q,  slot_tens_d;
    logic [CHANNELS-1:0][DIGIT_W-1:0] slot_units_q, slot_units_d;

    sched_state_e       state_q,      state_d;
    logic [CW-1:0]      grant_idx_q,  grant_idx_d;
    logic [CW-1:0]      last_grant_q, last_grant_d;
    logic [CW-1:0]      cur_chan_q,   cur_chan_d;
    logic [CNT_W-1:0]   dwell_cnt_q,  dwell_cnt_d;
    logic               disp_load_q,  disp_load_d;
    logic [DIGIT_W-1:0] disp_tens_q,  disp_tens_d;
    logic [DIGIT_W-1:0] disp_units_q, disp_units_d;

    logic          pick_any;
    logic [CW-1:0] pick_idx;

    rr_pick #(
        .CHANNELS (CHANNELS),
        .CW       (CW)
    ) u_pick (
        .full       (slot_full_q),
        .last_grant (last_grant_q),
        .any        (pick_any),
        .grant      (pick_idx)
    );

    // A slot only accepts while empty, so capture and the GRANT clear never hit the same slot.
    always_comb begin
        slot_full_d  = slot_full_q;
        slot_tens_d  = slot_tens_q;
        slot_units_d = slot_units_q;
        for (int i = 0; i < CHANNELS; i++) begin
            if (bus.req_valid[i] && !slot_full_q[i]) begin
                slot_full_d[i]  = 1'b1;
                slot_tens_d[i]  = clamp_digit(bus.req_tens[DIGIT_W*i +: DIGIT_W]);
                slot_units_d[i] = clamp_digit(bus.req_units[DIGIT_W*i +: DIGIT_W]);
            end
            if (state_q == ST_GRANT && grant_idx_q == CW'(i)) begin
                slot_full_d[i] = 1'b0;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_idx_d  = grant_idx_q;
        last_grant_d = last_grant_q;
        cur_chan_d   = cur_chan_q;
        dwell_cnt_d  = dwell_cnt_q;
        disp_load_d  = 1'b0;
        disp_tens_d  = disp_tens_q;
        disp_units_d = disp_units_q;

        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    grant_idx_d = pick_idx;
                    state_d     = ST_GRANT;
                end
            end
            ST_GRANT: begin
                disp_tens_d  = slot_tens_q[grant_idx_q];
                disp_units_d = slot_units_q[grant_idx_q];
                disp_load_d  = 1'b1;
                cur_chan_d   = grant_idx_q;
                last_grant_d = grant_idx_q;
                dwell_cnt_d  = '0;
                state_d      = ST_DWELL;
            end
            ST_DWELL: begin
                if (dwell_cnt_q == CNT_W'(DWELL - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    dwell_cnt_d = dwell_cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            slot_full_q  <= '0;
            slot_tens_q  <= '0;
            slot_units_q <= '0;
            state_q      <= ST_IDLE;
            grant_idx_q  <= '0;
            last_grant_q <= CW'(CHANNELS - 1);
            cur_chan_q   <= '0;
            dwell_cnt_q  <= '0;
            disp_load_q  <= 1'b0;
            disp_tens_q  <= '0;
            disp_units_q <= '0;
        end else begin
            slot_full_q  <= slot_full_d;
            slot_tens_q  <= slot_tens_d;
            slot_units_q <= slot_units_d;
            state_q      <= state_d;
            grant_idx_q  <= grant_idx_d;
            last_grant_q <= last_grant_d;
            cur_chan_q   <= cur_chan_d;
            dwell_cnt_q  <= dwell_cnt_d;
            disp_load_q  <= disp_load_d;
            disp_tens_q  <= disp_tens_d;
            disp_units_q <= disp_units_d;
        end
    end

    assign bus.req_ready  = ~slot_full_q;
    assign bus.disp_load  = disp_load_q;
    assign bus.disp_tens  = disp_tens_q;
    assign bus.disp_units = disp_units_q;
    assign bus.cur_chan   = cur_chan_q;
    assign bus.busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_display_scheduler.sv
// Directed self-checking bench for display_scheduler with CHANNELS=4, DWELL=5.
module tb_display_scheduler;

    localparam int CHANNELS = 4;
    localparam int DWELL    = 5;

    logic clk;
    logic reset;
    int   tests_run;
    int   tests_failed;

    display_scheduler_if #(.CHANNELS(CHANNELS)) bus ();

    display_scheduler #(
        .CHANNELS (CHANNELS),
        .DWELL    (DWELL)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] valid, input logic [15:0] tens, input logic [15:0] units);
        bus.req_valid = valid;
        bus.req_tens  = tens;
        bus.req_units = units;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic doReset();
        reset = 1'b1;
        applyStimulus(4'b0000, 16'h0000, 16'h0000);
        step();
        step();
        reset = 1'b0;
    endtask

    // Steps until disp_load is seen or the limit expires; n is the step count.
    task automatic waitLoad(input string tag, input int limit, output int n);
        bit seen;
        seen = 1'b0;
        n = 0;
        while (!seen && n < limit) begin
            step();
            n++;
            if (bus.disp_load) seen = 1'b1;
        end
        checkOutput({tag, "_seen"}, 32'(seen), 32'd1);
    endtask

    initial begin
        int n;
        int loads;
        int since;
        int pulses;
        logic [3:0] cur_t;
        logic [3:0] cur_u;
        logic [7:0] exp_q[$];
        logic [7:0] exp_v;
        bit pushed;

        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b1;
        applyStimulus(4'b0000, 16'h0000, 16'h0000);

        // Reset state
        doReset();
        checkOutput("rst_ready", 32'(bus.req_ready), 32'hF);
        checkOutput("rst_load", 32'(bus.disp_load), 32'd0);
        checkOutput("rst_tens", 32'(bus.disp_tens), 32'd0);
        checkOutput("rst_units", 32'(bus.disp_units), 32'd0);
        checkOutput("rst_chan", 32'(bus.cur_chan), 32'd0);
        checkOutput("rst_busy", 32'(bus.busy), 32'd0);

        // Single offer on channel 2: 3-cycle latency to disp_load
        applyStimulus(4'b0100, 16'h0400, 16'h0700);
        step();
        applyStimulus(4'b0000, 16'h0000, 16'h0000);
        checkOutput("t1_ready_low", 32'(bus.req_ready), 32'hB);
        checkOutput("t1_busy_idle", 32'(bus.busy), 32'd0);
        step();
        checkOutput("t1_busy_grant", 32'(bus.busy), 32'd1);
        checkOutput("t1_noload_grant", 32'(bus.disp_load), 32'd0);
        step();
        checkOutput("t1_load", 32'(bus.disp_load), 32'd1);
        checkOutput("t1_tens", 32'(bus.disp_tens), 32'd4);
        checkOutput("t1_units", 32'(bus.disp_units), 32'd7);
        checkOutput("t1_chan", 32'(bus.cur_chan), 32'd2);
        checkOutput("t1_ready_back", 32'(bus.req_ready), 32'hF);
        step();
        checkOutput("t1_load_pulse", 32'(bus.disp_load), 32'd0);
        checkOutput("t1_tens_hold", 32'(bus.disp_tens), 32'd4);
        step(); step(); step();
        checkOutput("t1_busy_dwell_end", 32'(bus.busy), 32'd1);
        step();
        checkOutput("t1_busy_back_idle", 32'(bus.busy), 32'd0);

        // Channels 0,1,3 together: round-robin order 0,1,3 spaced DWELL+2
        doReset();
        applyStimulus(4'b1011, 16'h5031, 16'h6042);
        step();
        applyStimulus(4'b0000, 16'h0000, 16'h0000);
        waitLoad("t2_a", 20, n);
        checkOutput("t2_a_latency", 32'(n), 32'd2);
        checkOutput("t2_a_chan", 32'(bus.cur_chan), 32'd0);
        checkOutput("t2_a_digits", {24'd0, bus.disp_tens, bus.disp_units}, 32'h12);
        waitLoad("t2_b", 20, n);
        checkOutput("t2_b_spacing", 32'(n), 32'(DWELL + 2));
        checkOutput("t2_b_chan", 32'(bus.cur_chan), 32'd1);
        checkOutput("t2_b_digits", {24'd0, bus.disp_tens, bus.disp_units}, 32'h34);
        waitLoad("t2_c", 20, n);
        checkOutput("t2_c_spacing", 32'(n), 32'(DWELL + 2));
        checkOutput("t2_c_chan", 32'(bus.cur_chan), 32'd3);
        checkOutput("t2_c_digits", {24'd0, bus.disp_tens, bus.disp_units}, 32'h56);

        // Out-of-range digits clamp to 9
        doReset();
        applyStimulus(4'b0010, 16'h00C0, 16'h00F0);
        step();
        applyStimulus(4'b0000, 16'h0000, 16'h0000);
        waitLoad("t3", 20, n);
        checkOutput("t3_chan", 32'(bus.cur_chan), 32'd1);
        checkOutput("t3_clamp", {24'd0, bus.disp_tens, bus.disp_units}, 32'h99);

        // Channel 1 offering continuously: every accepted value shown in order
        doReset();
        cur_t = 4'd1;
        cur_u = 4'd3;
        loads = 0;
        since = 0;
        applyStimulus(4'b0010, {8'h00, cur_t, 4'h0}, {8'h00, cur_u, 4'h0});
        for (int c = 0; c < 40 && loads < 4; c++) begin
            pushed = 1'b0;
            if (bus.req_ready[1]) begin
                exp_q.push_back({cur_t, cur_u});
                pushed = 1'b1;
            end
            step();
            since++;
            if (pushed) begin
                cur_t = (cur_t == 4'd9) ? 4'd0 : cur_t + 4'd1;
                cur_u = (cur_u >= 4'd7) ? cur_u - 4'd7 : cur_u + 4'd2;
                applyStimulus(4'b0010, {8'h00, cur_t, 4'h0}, {8'h00, cur_u, 4'h0});
            end
            if (bus.disp_load) begin
                exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                checkOutput("t4_value", {24'd0, bus.disp_tens, bus.disp_units}, {24'd0, exp_v});
                if (loads > 0) checkOutput("t4_spacing", 32'(since), 32'(DWELL + 2));
                since = 0;
                loads++;
            end else if (since == 3 && loads > 0) begin
                checkOutput("t4_ready_low", 32'(bus.req_ready[1]), 32'd0);
            end
        end
        checkOutput("t4_load_count", 32'(loads), 32'd4);
        applyStimulus(4'b0000, 16'h0000, 16'h0000);

        // Reset during DWELL with a pending slot discards everything
        doReset();
        applyStimulus(4'b0001, 16'h0002, 16'h0003);
        step();
        applyStimulus(4'b0000, 16'h0000, 16'h0000);
        waitLoad("t5", 20, n);
        applyStimulus(4'b0100, 16'h0800, 16'h0100);
        step();
        applyStimulus(4'b0000, 16'h0000, 16'h0000);
        checkOutput("t5_pending", 32'(bus.req_ready), 32'hB);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        checkOutput("t5_load", 32'(bus.disp_load), 32'd0);
        checkOutput("t5_tens", 32'(bus.disp_tens), 32'd0);
        checkOutput("t5_units", 32'(bus.disp_units), 32'd0);
        checkOutput("t5_chan", 32'(bus.cur_chan), 32'd0);
        checkOutput("t5_busy", 32'(bus.busy), 32'd0);
        checkOutput("t5_ready", 32'(bus.req_ready), 32'hF);
        pulses = 0;
        for (int c = 0; c < 12; c++) begin
            step();
            if (bus.disp_load || bus.busy) pulses++;
        end
        checkOutput("t5_quiet", 32'(pulses), 32'd0);

        // Channel 0 refilled every grant while channel 3 waits
        doReset();
        applyStimulus(4'b1001, 16'h7001, 16'h7001);
        step();
        applyStimulus(4'b0001, 16'h0001, 16'h0001);
        waitLoad("t6_a", 20, n);
        checkOutput("t6_a_chan", 32'(bus.cur_chan), 32'd0);
        waitLoad("t6_b", 20, n);
`ifdef SCHED_PRIORITY_EN
        checkOutput("t6_b_chan", 32'(bus.cur_chan), 32'd0);
`else
        checkOutput("t6_b_chan", 32'(bus.cur_chan), 32'd3);
        checkOutput("t6_b_digits", {24'd0, bus.disp_tens, bus.disp_units}, 32'h77);
`endif
        waitLoad("t6_c", 20, n);
        checkOutput("t6_c_chan", 32'(bus.cur_chan), 32'd0);
`ifdef SCHED_PRIORITY_EN
        checkOutput("t6_ch3_pending", 32'(bus.req_ready[3]), 32'd0);
`else
        checkOutput("t6_ch3_pending", 32'(bus.req_ready[3]), 32'd1);
`endif
        applyStimulus(4'b0000, 16'h0000, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/display_scheduler.md
# display_scheduler

Time-shares the single two-digit seven-segment display between CHANNELS independent frequency-measurement channels. Each channel hands over a finished tens/units result through a valid/ready handshake into a one-deep per-channel slot. The scheduler grants channels with pending results in round-robin order and drives the display's load port. It holds each shown result for DWELL cycles so a human can read it. It sits between the measurement channels and the seven-segment driver.

## Interface
- CHANNELS, 4, number of measurement channels (2..8)
- DWELL, 1200, cycles a granted result stays on the display before the next grant (≥1)
- CW, $clog2(CHANNELS), channel index width (derived)

- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- req_valid  in  CHANNELS  per-channel result offered
- req_tens  in  4*CHANNELS  tens digit, channel i at [4i+3:4i]
- req_units  in  4*CHANNELS  units digit, same packing
- req_ready  out  CHANNELS  per-channel slot empty, result accepted when valid&ready
- disp_load  out  1  one-cycle pulse, new digits valid this cycle
- disp_tens  out  4  tens digit to display driver
- disp_units  out  4  units digit to display driver
- cur_chan  out  CW  channel currently shown
- busy  out  1  high in GRANT and DWELL

## Operation
- Reset: all slots empty (req_ready all 1), disp_load=0, disp_tens=0, disp_units=0, cur_chan=0, busy=0, state IDLE, last_grant=CHANNELS-1.
- Slot i: captures req_tens/req_units on valid&ready, becomes full; req_ready[i]=!full[i] (registered state, no combinational path from req_valid).
- Digits >9 are clamped to 9 on capture.
- States:
  - IDLE: if any slot is full, pick the winner and latch grant_idx, then go to GRANT. Otherwise stay.
  - GRANT: copy slot[grant_idx] to disp regs, clear slot, register disp_load=1, cur_chan=grant_idx, last_grant=grant_idx, clear dwell counter, go to DWELL.
  - DWELL: disp_load=0 after its single cycle. Count up; when count==DWELL-1, go to IDLE.
- Round-robin pick: first full slot searching last_grant+1, last_grant+2, … modulo CHANNELS.
- A slot refilled during DWELL waits. A channel offering while its slot is full stalls (ready low); no result is dropped.
- Capture and clear of the same slot never coincide, because ready is low while full.
- Reset mid-DWELL or mid-GRANT aborts immediately to reset values. A pending grant is discarded.

## Timing
- Accept at cycle a → slot full a+1 → IDLE selects at a+1 → GRANT at a+2 → disp_load high with new digits at a+3 (3-cycle latency when idle).
- The slot's req_ready returns high at a+3.
- disp_load is high for exactly 1 cycle. disp_tens/disp_units/cur_chan are stable from that cycle until the next disp_load.
- Minimum spacing between disp_load pulses: DWELL+2 cycles (DWELL in DWELL state, plus IDLE and GRANT).
- dwell counter width $clog2(DWELL+1), no wrap.

## Configuration
- SCHED_PRIORITY_EN defined: fixed priority replaces round-robin. The lowest-index full slot always wins, and last_grant is ignored. A continuously refilled channel 0 can starve others.
- Undefined: round-robin as above (default build).

## Structure
- Shared package freq_counter_pkg holds:
  - state encoding typedef (IDLE, GRANT, DWELL)
  - digit width constant 4
  - clamp value 9
  - default DWELL 1200
- One sub-module, rr_pick: combinational; inputs full mask and last_grant; outputs any and grant index. Fixed-priority variant under SCHED_PRIORITY_EN.

## Test plan
- Reset then channel 2 offers tens=4, units=7 at cycle 10 → req_ready[2] low at 11; disp_load pulse at 13 with disp_tens=4, disp_units=7, cur_chan=2; req_ready[2] high at 13.
- Channels 0,1,3 all valid at the same cycle, DWELL=5 → grants in order 0,1,3; disp_load pulses exactly 7 cycles apart.
- Channel 1 offers continuously with others idle → one display every DWELL+2 cycles. Between grants, req_ready[1] is low while its slot is full; no accepted value is skipped.
- Input tens=12, units=15 → displayed 9, 9.
- Reset asserted in DWELL with a full slot pending → next cycle all outputs 0, all req_ready 1, busy 0; no disp_load until a new offer.
- With SCHED_PRIORITY_EN, channel 0 refilled every grant and channel 3 pending → channel 3 never granted; without the macro, channel 3 is granted within two dwell periods.
